wb_memtest: RTL

- Wishbone classic initiator that exercises the external x8 SRAM through the 32-bit Wishbone SRAM responder.
- Two passes over a word range: a write pass of a 32-bit LFSR pattern, then a read-back pass that compares each word against a regenerated LFSR.
- Used for power-on self-test and on demand from a CPU-side control register; sits beside the CPU as a second bus master behind the arbiter.

---
 rtl/wb_memtest.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_memtest.sv
// Wishbone classic initiator: writes a 32-bit Galois LFSR pattern over a word
// range of the SRAM, then reads it back and compares against a regenerated LFSR.
// Stops on the first mismatch or ack timeout and records the failing transfer.
module wb_memtest #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] POLY    = 32'h00400007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [14:0] base_i,
  input  logic [15:0] count_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        tmo_o,
  output logic [16:0] fail_adr_o,
  output logic [31:0] fail_exp_o,
  output logic [31:0] fail_got_o,
  output logic [16:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FINISH
  } state_t;

  // Wait counter value on which the next ack-less cycle triggers the abort.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [14:0] base_q, base_d;
  logic [15:0] count_q, count_d;
  logic [31:0] seed_q, seed_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  wait_q, wait_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [16:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic        tmo_q, tmo_d;
  logic [16:0] fail_adr_q, fail_adr_d;
  logic [31:0] fail_exp_q, fail_exp_d;
  logic [31:0] fail_got_q, fail_got_d;

  logic [31:0] seed_eff;
  logic [14:0] next_word;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? POLY : '0);
  endfunction

  assign seed_eff  = (seed_i == '0) ? 32'h1 : seed_i;
  // 15-bit add wraps the word address at the top of the device.
  assign next_word = base_q + idx_q[14:0];

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      seed_q     <= '0;
      lfsr_q     <= '0;
      idx_q      <= '0;
      wait_q     <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
      fail_adr_q <= '0;
      fail_exp_q <= '0;
      fail_got_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      seed_q     <= seed_d;
      lfsr_q     <= lfsr_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
      fail_adr_q <= fail_adr_d;
      fail_exp_q <= fail_exp_d;
      fail_got_q <= fail_got_d;
    end
  end

  // Next-state and next-output logic for the write/read-back sequence.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    seed_d     = seed_q;
    lfsr_d     = lfsr_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fail_d     = fail_q;
    tmo_d      = tmo_q;
    fail_adr_d = fail_adr_q;
    fail_exp_d = fail_exp_q;
    fail_got_d = fail_got_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d     = base_i;
          count_d    = count_i;
          seed_d     = seed_eff;
          lfsr_d     = seed_eff;
          idx_d      = '0;
          wait_d     = '0;
          busy_d     = 1'b1;
          fail_d     = 1'b0;
          tmo_d      = 1'b0;
          fail_adr_d = '0;
          fail_exp_d = '0;
          fail_got_d = '0;
          if (count_i == '0) begin
            state_d = FINISH;
          end else begin
            state_d = WR_REQ;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            adr_d   = {base_i, 2'b00};
            dat_d   = seed_eff;
          end
        end
      end

      WR_REQ: begin
        if (ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          lfsr_d  = lfsr_step(lfsr_q);
          idx_d   = idx_q + 16'd1;
          state_d = WR_GAP;
        end else if (wait_q == TMO_LAST) begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          we_d       = 1'b0;
          fail_d     = 1'b1;
          tmo_d      = 1'b1;
          fail_adr_d = adr_q;
          fail_exp_d = dat_q;
          fail_got_d = '0;
          state_d    = FINISH;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      WR_GAP: begin
        cyc_d  = 1'b1;
        stb_d  = 1'b1;
        wait_d = '0;
        if (idx_q == count_q) begin
          lfsr_d  = seed_q;
          idx_d   = '0;
          we_d    = 1'b0;
          adr_d   = {base_q, 2'b00};
          state_d = RD_REQ;
        end else begin
          we_d    = 1'b1;
          adr_d   = {next_word, 2'b00};
          dat_d   = lfsr_q;
          state_d = WR_REQ;
        end
      end

      RD_REQ: begin
        if (ack_i) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (dat_i != lfsr_q) begin
            fail_d     = 1'b1;
            fail_adr_d = adr_q;
            fail_exp_d = lfsr_q;
            fail_got_d = dat_i;
            state_d    = FINISH;
          end else begin
            lfsr_d  = lfsr_step(lfsr_q);
            idx_d   = idx_q + 16'd1;
            state_d = RD_GAP;
          end
        end else if (wait_q == TMO_LAST) begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          fail_d     = 1'b1;
          tmo_d      = 1'b1;
          fail_adr_d = adr_q;
          fail_exp_d = lfsr_q;
          fail_got_d = '0;
          state_d    = FINISH;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      RD_GAP: begin
        if (idx_q == count_q) begin
          state_d = FINISH;
        end else begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          wait_d  = '0;
          adr_d   = {next_word, 2'b00};
          state_d = RD_REQ;
        end
      end

      FINISH: begin
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign fail_o     = fail_q;
  assign tmo_o      = tmo_q;
  assign fail_adr_o = fail_adr_q;
  assign fail_exp_o = fail_exp_q;
  assign fail_got_o = fail_got_q;
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign sel_o      = 4'hF;
  assign we_o       = we_q;
  assign cyc_o      = cyc_q;
  assign stb_o      = stb_q;

endmodule
